// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared router types and constants: port count, req/grant
//                bit positions, destination field width, requester FSM
//                states and the destination-to-request decode.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int DEST_W    = 3;

    // Bit positions of each output port inside req/grant
    localparam int PORT_0 = 0;
    localparam int PORT_1 = 1;
    localparam int PORT_2 = 2;
    localparam int PORT_3 = 3;
    localparam int PORT_4 = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_DROP = 2'd3
    } req_state_t;

    // Destinations 5..7 decode to all-zero, which marks the flit as invalid
    function automatic logic [NUM_PORTS-1:0] dest_to_req(input logic [DEST_W-1:0] dest);
        logic [NUM_PORTS-1:0] onehot;
        onehot = '0;
        case (dest)
            3'd0:    onehot[PORT_0] = 1'b1;
            3'd1:    onehot[PORT_1] = 1'b1;
            3'd2:    onehot[PORT_2] = 1'b1;
            3'd3:    onehot[PORT_3] = 1'b1;
            3'd4:    onehot[PORT_4] = 1'b1;
            default: onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : flit_fifo
//  Description : Circular-buffer flit FIFO with head output and a peek at a
//                field of the entry that becomes head after the current pop
//                (which may be the flit being pushed in the same cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module flit_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int PEEK_LSB   = 61,
    parameter int PEEK_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_next_avail,
    output logic [PEEK_W-1:0]     o_next_peek
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;

    logic                  w_push;
    logic                  w_pop;
    logic [c_AW-1:0]       w_rd_ptr_nxt;
    logic                  w_two_plus;

    assign o_full       = (r_count == c_CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    // A push while full is legal only together with a pop
    assign w_push       = i_push && (!o_full || i_pop);
    assign w_pop        = i_pop && !o_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + c_AW'(1);
    assign w_two_plus   = (r_count >= c_CW'(2));
    assign o_head       = r_mem[r_rd_ptr];
    // After a pop something remains if a second entry exists or one arrives now
    assign o_next_avail = w_two_plus || w_push;
    assign o_next_peek  = w_two_plus ? r_mem[w_rd_ptr_nxt][PEEK_LSB +: PEEK_W]
                                     : i_wdata[PEEK_LSB +: PEEK_W];

    // Storage write; contents need no reset since count qualifies them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_port_requester.sv
`default_nettype none
// ============================================================================
//  Module      : input_port_requester
//  Description : Router input port. Buffers flits, raises a one-hot request
//                toward the output arbiters from the head destination, holds
//                it until a matching grant, then sends the flit for one cycle.
//                Flits with destinations 5..7 are dropped and counted.
//  Revision    : 1.0  initial release
// ============================================================================
module input_port_requester
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int DEST_LSB   = 61
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]  req,
    input  logic [NUM_PORTS-1:0]  grant,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [7:0]            drop_cnt
);

    req_state_t            r_state;
    req_state_t            w_state_nxt;
    logic [NUM_PORTS-1:0]  r_req;
    logic [NUM_PORTS-1:0]  w_req_nxt;
    logic                  r_out_valid;
    logic                  w_out_valid_nxt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [7:0]            r_drop_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_drop_inc;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_next_avail;
    logic [DEST_W-1:0]     w_next_dest;
    logic [NUM_PORTS-1:0]  w_head_req;
    logic [NUM_PORTS-1:0]  w_next_req;

    assign in_ready  = !w_full;
    assign w_push    = in_valid && in_ready;
    assign req       = r_req;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign drop_cnt  = r_drop_cnt;

    assign w_head_req = dest_to_req(w_head[DEST_LSB +: DEST_W]);
    assign w_next_req = dest_to_req(w_next_dest);

    flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PEEK_LSB   (DEST_LSB),
        .PEEK_W     (DEST_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_wdata      (in_data),
        .i_pop        (w_pop),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head       (w_head),
        .o_next_avail (w_next_avail),
        .o_next_peek  (w_next_dest)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, next registered outputs, and pop/drop strobes
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_out_valid_nxt = 1'b0;
        w_load          = 1'b0;
        w_pop           = 1'b0;
        w_drop_inc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_nxt = '0;
                if (!w_empty) begin
                    w_req_nxt   = w_head_req;
                    w_state_nxt = (|w_head_req) ? ST_REQ : ST_DROP;
                end
            end
            ST_REQ: begin
                // Only a grant bit matching the held request counts
                if (|(grant & r_req)) begin
                    w_state_nxt     = ST_SEND;
                    w_req_nxt       = '0;
                    w_out_valid_nxt = 1'b1;
                    w_load          = 1'b1;
                end
            end
            ST_SEND, ST_DROP: begin
                w_pop      = 1'b1;
                w_drop_inc = (r_state == ST_DROP);
                w_req_nxt  = '0;
                if (w_next_avail) begin
                    w_req_nxt   = w_next_req;
                    w_state_nxt = (|w_next_req) ? ST_REQ : ST_DROP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = '0;
            end
        endcase
    end

    // Registered request, crossbar outputs and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_req       <= w_req_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_load) r_out_data <= w_head;
            if (w_drop_inc && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_port_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_port_requester
//  Description : Self-checking bench for input_port_requester with an
//                expected-flit scoreboard compared on every out_valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_port_requester;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [4:0]  req;
    logic [4:0]  grant;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  drop_cnt;

    int          n_checks;
    int          n_pass;
    logic [63:0] sb[$];

    input_port_requester #(
        .DATA_WIDTH (64),
        .DEPTH      (4),
        .DEST_LSB   (61)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every crossbar pulse must match the oldest expected flit
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: out_valid with data %h, no flit expected", out_data);
            end else begin
                logic [63:0] exp_flit;
                exp_flit = sb.pop_front();
                if (out_data !== exp_flit) $display("FAIL sb_data: got %h want %h", out_data, exp_flit);
                else n_pass++;
            end
        end
    end

    function automatic logic [63:0] mk(input int dest, input int pay);
        logic [63:0] v;
        v = 64'(pay);
        v[63:61] = 3'(dest);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (req !== 5'b0) $display("FAIL rst_req: got %b want %b", req, 5'b0); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); else n_pass++;
        n_checks++; if (out_data !== 64'd0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    endtask

    task automatic test_single();
        logic [63:0] f;
        f = mk(2, 32'h1234);
        in_valid = 1'b1; in_data = f; sb.push_back(f);
        tick();
        in_valid = 1'b0;
        n_checks++; if (req !== 5'b0) $display("FAIL single_req_e0: got %b want %b", req, 5'b0); else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (req !== 5'b00100) $display("FAIL single_req_hold: got %b want %b", req, 5'b00100); else n_pass++;
            if (i < 2) tick();
        end
        grant = 5'b00100;
        tick();
        grant = 5'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (req !== 5'b0) $display("FAIL single_req_send: got %b want %b", req, 5'b0); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_pulse_end: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== f) $display("FAIL single_data_hold: got %h want %h", out_data, f); else n_pass++;
        tick();
        n_checks++; if (req !== 5'b0) $display("FAIL single_idle_req: got %b want %b", req, 5'b0); else n_pass++;
    endtask

    task automatic test_wrong_grant();
        logic [63:0] f;
        grant = 5'b11111;
        tick();
        grant = 5'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_grant: got out_valid %b want 0", out_valid); else n_pass++;
        f = mk(3, 32'h5555);
        in_valid = 1'b1; in_data = f; sb.push_back(f);
        tick();
        in_valid = 1'b0;
        tick();
        grant = 5'b00010;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (req !== 5'b01000 || out_valid !== 1'b0)
                $display("FAIL wrong_grant: got req %b out_valid %b want req %b out_valid 0", req, out_valid, 5'b01000);
            else n_pass++;
            tick();
        end
        grant = 5'b01000;
        tick();
        grant = 5'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL right_grant: got out_valid %b want 1", out_valid); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_fill();
        logic [63:0] f[5];
        int          d[5];
        d = '{0, 1, 4, 2, 3};
        for (int i = 0; i < 5; i++) f[i] = mk(d[i], 100 + i);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = f[i];
            n_checks++; if (in_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %b want 1", i, in_ready); else n_pass++;
            sb.push_back(f[i]);
            tick();
        end
        in_data = f[4];
        n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_full: got in_ready %b want 0", in_ready); else n_pass++;
        n_checks++; if (req !== 5'b00001) $display("FAIL fill_req0: got %b want %b", req, 5'b00001); else n_pass++;
        grant = 5'b00001;
        tick();
        grant = 5'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_send_full: got in_ready %b want 0", in_ready); else n_pass++;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL fill_ready_rise: got %b want 1", in_ready); else n_pass++;
        sb.push_back(f[4]);
        tick();
        in_valid = 1'b0;
        for (int j = 1; j < 5; j++) begin
            int waited;
            logic [4:0] exp_req;
            exp_req = 5'b1 << d[j];
            waited = 0;
            while (req === 5'b0 && waited < 8) begin
                tick();
                waited++;
            end
            n_checks++; if (req !== exp_req) $display("FAIL fill_req_%0d: got %b want %b", j, req, exp_req); else n_pass++;
            grant = req;
            tick();
            grant = 5'b0;
            tick();
        end
        n_checks++; if (in_ready !== 1'b1) $display("FAIL fill_drained: got in_ready %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_invalid();
        logic [63:0] f;
        f = mk(1, 32'hBEEF);
        in_valid = 1'b1; in_data = mk(6, 32'hDEAD);
        tick();
        in_data = f; sb.push_back(f);
        tick();
        in_valid = 1'b0;
        n_checks++; if (req !== 5'b0) $display("FAIL inv_no_req: got %b want %b", req, 5'b0); else n_pass++;
        tick();
        n_checks++; if (drop_cnt !== 8'd1) $display("FAIL inv_drop_cnt: got %0d want 1", drop_cnt); else n_pass++;
        n_checks++; if (req !== 5'b00010) $display("FAIL inv_next_req: got %b want %b", req, 5'b00010); else n_pass++;
        grant = 5'b00010;
        tick();
        grant = 5'b0;
        tick();
        tick();
        n_checks++; if (drop_cnt !== 8'd1) $display("FAIL inv_drop_hold: got %0d want 1", drop_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d[3];
        d = '{4, 0, 1};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = mk(d[i], 200 + i);
            sb.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (req !== 5'b10000) $display("FAIL rmid_req: got %b want %b", req, 5'b10000); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_checks++; if (req !== 5'b0) $display("FAIL rmid_req_clr: got %b want %b", req, 5'b0); else n_pass++;
        n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rmid_drop_clr: got %0d want 0", drop_cnt); else n_pass++;
        grant = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (req !== 5'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL rmid_quiet: got req %b out_valid %b in_ready %b want 00000 0 1", req, out_valid, in_ready);
            else n_pass++;
        end
        grant = 5'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        grant    = '0;
        tick();
        test_reset();
        test_single();
        test_wrong_grant();
        test_fill();
        test_invalid();
        test_reset_mid();
        tick();
        n_checks++; if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/input_port_requester.md
# input_port_requester

Requester side of the router's req/grant handshake. Buffers incoming single-flit packets, decodes each head flit's destination field into a one-hot 5-bit request toward the output-port round-robin arbiters, and holds that request until the matching grant returns. It then drives the flit onto the crossbar for one cycle and pops it. One instance per router input port.

## Interface
- DATA_WIDTH, 64, flit width in bits.
- DEPTH, 4, input FIFO depth in flits (power of 2, ≥2).
- DEST_LSB, 61, LSB of the 3-bit destination field `in_data[DEST_LSB+2:DEST_LSB]`.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream flit valid.
- in_ready  output  1  FIFO not full; a flit is accepted when in_valid && in_ready at a rising edge.
- in_data  input  DATA_WIDTH  upstream flit.
- req  output  5  one-hot request; bit i targets output port i (00001 = port 0, 01000 = port 3, 10000 = port 4).
- grant  input  5  bit i = output-port-i arbiter grants this input.
- out_valid  output  1  crossbar flit valid, one cycle per flit.
- out_data  output  DATA_WIDTH  crossbar flit.
- drop_cnt  output  8  saturating count of flits dropped for an invalid destination.

## Operation
- FIFO: circular buffer with DEPTH entries and a count of width log2(DEPTH)+1.
  - in_ready = (count != DEPTH).
  - Push and pop in the same cycle leave count unchanged and are legal when full.
- Destination decode: dest = head[DEST_LSB+2:DEST_LSB].
  - Values 0–4 map to req = 1<<dest.
  - Values 5–7 are invalid.
- FSM states:
  - IDLE: FIFO empty; req = 0.
  - REQ: req registered from the head dest; held stable until (grant & req) != 0.
  - SEND: out_valid = 1 and out_data = head; req = 0; head popped at the end of the cycle.
  - DROP: head popped without any request; drop_cnt += 1, saturating at 255.
- Transitions:
  - IDLE → REQ when the FIFO is non-empty and the head is valid.
  - IDLE → DROP when the FIFO is non-empty and the head is invalid.
  - REQ → SEND when (grant & req) != 0.
  - SEND → REQ or DROP (by the next head) if count after pop > 0; otherwise SEND → IDLE.
  - DROP → same rule as SEND.
- Grant bits that do not match req, including multi-bit grants, are ignored. A grant that arrives while req = 0 is ignored.
- out_data holds its last value when out_valid = 0.

## Timing
- Reset values: req = 0, out_valid = 0, out_data = 0, drop_cnt = 0, in_ready = 1, FIFO empty, state IDLE.
- Reset mid-operation flushes the FIFO and drops any pending request. Outputs reach their reset values after the edge where rst is sampled high.
- Accept at edge E0 into an empty FIFO:
  - req is visible after E1.
  - Grant sampled at edge Ek (k ≥ 2) → out_valid high for the cycle after Ek.
  - Pop occurs at Ek+1.
- Minimum request-to-send latency is one cycle. Peak throughput is one flit per 2 cycles (REQ, SEND) when the next head follows immediately.
- in_ready is combinational from the registered count. It rises in the cycle after a pop from a full FIFO.

## Structure
- Shared package router_pkg holds:
  - NUM_PORTS = 5.
  - Port index constants PORT_0..PORT_4 (bit positions of req/grant).
  - The FSM state enum.
  - DEST_W = 3.
- One sub-module, flit_fifo (parameterised DATA_WIDTH, DEPTH), provides push/pop/full/empty/head. The FSM and decode live in the top module.

## Test plan
- Reset then idle: rst high 1 cycle → req = 00000, out_valid = 0, in_ready = 1, drop_cnt = 0.
- Single flit, dest = 2, grant = 00100 three cycles after req rises → req = 00100 held those cycles, then one out_valid pulse with out_data equal to the sent flit, req = 00000, FIFO empty.
- Wrong grant: dest = 3, grant = 00010 for 4 cycles, then 01000 → no out_valid until 01000; req stays 01000 throughout.
- Fill: push 5 flits back-to-back with no grant → in_ready falls after the 4th accept; the 5th is held. After one grant + SEND, in_ready rises and the 5th is accepted. Output order matches input order.
- Invalid dest: flits with dest = 6 then dest = 1 → no request for the first, drop_cnt = 1, req = 00010 for the second.
- Reset mid-request: req = 10000 with 3 flits queued, rst for 1 cycle → req = 00000, FIFO empty, no out_valid afterwards.
